// File: rtl/rf_scatter_accum_pkg.sv
// rtl/rf_scatter_accum_pkg.sv - shared types, widths and coordinate helpers for the scatter accumulator
`ifndef W_C_LENGTH
`define W_C_LENGTH 1024
`endif

package rf_scatter_accum_pkg;

  localparam int OUT_H  = 8;
  localparam int OUT_W  = 8;
  localparam int OUT_K  = 16;
  localparam int AW     = 8;
  localparam int WW     = 8;
  localparam int ACC_W  = 24;
  localparam int PW     = AW + WW;
  localparam int DEPTH  = OUT_H * OUT_W * OUT_K;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = 11;

  typedef logic [2:0][6:0]          coord_t;
  typedef logic signed [ACC_W-1:0]  psum_t;
  typedef logic signed [PW-1:0]     prod_t;

  localparam psum_t PSUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam psum_t PSUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Coordinates are unsigned, so an underflowed h-r lands high and fails the compare.
  function automatic logic coord_in_range(input coord_t c);
    return (c[0] < 7'(OUT_H)) && (c[1] < 7'(OUT_W)) && (c[2] < 7'(OUT_K));
  endfunction

  function automatic logic [ADDR_W-1:0] coord_addr(input coord_t c);
    return ADDR_W'((int'(c[0]) * OUT_W + int'(c[1])) * OUT_K + int'(c[2]));
  endfunction

endpackage

// File: rtl/rf_scatter_accum_if.sv
// rtl/rf_scatter_accum_if.sv - idle-time psum readout port
interface rf_scatter_accum_if
  import rf_scatter_accum_pkg::*;
();
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  psum_t             o_rd_data;

  modport master (output i_rd_en, output i_rd_addr, input  o_rd_data);
  modport slave  (input  i_rd_en, input  i_rd_addr, output o_rd_data);
endinterface

// File: rtl/rf_scatter_accum_acc_buf_ram.sv
// rtl/rf_scatter_accum_acc_buf_ram.sv - 1R1W psum RAM, registered read, old data on same-address collision
module rf_scatter_accum_acc_buf_ram
  import rf_scatter_accum_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output psum_t             o_rdata,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  psum_t             i_wdata
);

  psum_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rf_scatter_accum.sv
// rtl/rf_scatter_accum.sv - walks the coordinate RF, multiplies by one activation and
// scatter-accumulates saturating partial sums into the owned psum buffer
module rf_scatter_accum
  import rf_scatter_accum_pkg::*;
#(
  parameter int LENGTH = `W_C_LENGTH
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_start,
  input  logic [CNT_W-1:0]       i_length,
  input  coord_t                 i_RF     [LENGTH],
  input  logic signed [WW-1:0]   i_weight [LENGTH],
  input  logic signed [AW-1:0]   i_act,
  rf_scatter_accum_if.slave      rd,
  output logic                   o_busy,
  output logic                   o_finish,
  output logic [CNT_W-1:0]       o_drop_cnt
);

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [ADDR_W:0]   r_clr_cnt;
  logic              r_finish;
  logic              r_p0_vld, r_p0_inr, r_p1_vld, r_p1_inr, r_lw_vld;
  logic [ADDR_W-1:0] r_p0_addr, r_p1_addr, r_lw_addr;
  prod_t             r_p0_prod, r_p1_prod;
  psum_t             r_lw_data;
  logic              r_rd_sel;
  psum_t             r_rd_hold;

  logic [IDX_W-1:0]  w_idx;
  coord_t            w_coord;
  prod_t             w_prod;
  logic              w_last;
  logic              w_clr_we, w_run_we, w_rd_acc;
  logic              w_ram_re, w_ram_we;
  logic [ADDR_W-1:0] w_ram_raddr, w_ram_waddr;
  psum_t             w_ram_wdata, w_ram_q, w_old, w_sat;
  logic [ACC_W:0]    w_sum;

  assign w_idx   = r_idx[IDX_W-1:0];
  assign w_coord = i_RF[w_idx];
  assign w_prod  = PW'(i_act) * PW'(i_weight[w_idx]);
  assign w_last  = (r_idx == i_length - 11'd1);

  assign o_busy     = (r_state != S_IDLE);
  assign o_finish   = r_finish;
  assign o_drop_cnt = r_drop_cnt;

  assign w_clr_we = (r_state == S_CLEAR) && (r_clr_cnt != (ADDR_W+1)'(DEPTH));
  assign w_run_we = r_p1_vld && r_p1_inr;
  assign w_rd_acc = rd.i_rd_en && !o_busy;

  // The pipeline owns the read port whenever busy; readout only gets it in IDLE.
  assign w_ram_re    = o_busy ? r_p0_vld  : w_rd_acc;
  assign w_ram_raddr = o_busy ? r_p0_addr : rd.i_rd_addr;
  assign w_ram_we    = w_clr_we || w_run_we;
  assign w_ram_waddr = w_clr_we ? r_clr_cnt[ADDR_W-1:0] : r_p1_addr;
  assign w_ram_wdata = w_clr_we ? '0 : w_sat;

  rf_scatter_accum_acc_buf_ram u_ram (
    .i_clk   (i_clk),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata)
  );

  // The read for this entry was issued in the same cycle as the previous entry's write.
  assign w_old = (r_lw_vld && (r_lw_addr == r_p1_addr)) ? r_lw_data : w_ram_q;
  assign w_sum = {w_old[ACC_W-1], w_old} + (ACC_W+1)'(r_p1_prod);

  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) w_sat = w_sum[ACC_W] ? PSUM_MIN : PSUM_MAX;
  end

  assign rd.o_rd_data = r_rd_sel ? w_ram_q : r_rd_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_drop_cnt <= '0;
      r_clr_cnt  <= '0;
      r_finish   <= 1'b0;
      r_p0_vld   <= 1'b0;
      r_p0_inr   <= 1'b0;
      r_p0_addr  <= '0;
      r_p0_prod  <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_inr   <= 1'b0;
      r_p1_addr  <= '0;
      r_p1_prod  <= '0;
      r_lw_vld   <= 1'b0;
      r_lw_addr  <= '0;
      r_lw_data  <= '0;
      r_rd_sel   <= 1'b0;
      r_rd_hold  <= '0;
    end else begin
      r_finish  <= 1'b0;
      r_p0_vld  <= 1'b0;
      r_p1_vld  <= r_p0_vld;
      r_p1_inr  <= r_p0_inr;
      r_p1_addr <= r_p0_addr;
      r_p1_prod <= r_p0_prod;
      r_lw_vld  <= w_run_we;
      r_lw_addr <= r_p1_addr;
      r_lw_data <= w_sat;
      r_rd_sel  <= w_rd_acc;
      if (r_rd_sel) r_rd_hold <= w_ram_q;

      case (r_state)
        S_IDLE: begin
          if (i_clear) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end else if (i_start) begin
            r_idx      <= '0;
            r_drop_cnt <= '0;
            r_state    <= (i_length == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == (ADDR_W+1)'(DEPTH)) begin
            r_state  <= S_IDLE;
            r_finish <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_p0_vld  <= 1'b1;
          r_p0_inr  <= coord_in_range(w_coord);
          r_p0_addr <= coord_addr(w_coord);
          r_p0_prod <= w_prod;
          if (!coord_in_range(w_coord)) r_drop_cnt <= r_drop_cnt + 1'b1;
          r_idx <= r_idx + 1'b1;
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!r_p0_vld && !r_p1_vld) begin
            r_state  <= S_IDLE;
            r_finish <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_scatter_accum.sv
// tb/tb_rf_scatter_accum.sv - directed scoreboard bench for rf_scatter_accum
module tb_rf_scatter_accum;
  import rf_scatter_accum_pkg::*;

  localparam int LEN = `W_C_LENGTH;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_clear, i_start;
  logic [CNT_W-1:0]     len;
  coord_t               rf  [LEN];
  logic signed [WW-1:0] wt  [LEN];
  logic signed [AW-1:0] act;
  logic                 o_busy, o_finish;
  logic [CNT_W-1:0]     o_drop_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int model [DEPTH];
  logic signed [63:0] exp_q [$];

  rf_scatter_accum_if rd_if ();

  rf_scatter_accum #(.LENGTH(LEN)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (i_clear),
    .i_start    (i_start),
    .i_length   (len),
    .i_RF       (rf),
    .i_weight   (wt),
    .i_act      (act),
    .rd         (rd_if),
    .o_busy     (o_busy),
    .o_finish   (o_finish),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_entry(input int n, input int h, input int w, input int k, input int g);
    rf[n][0] = 7'(h);
    rf[n][1] = 7'(w);
    rf[n][2] = 7'(k);
    wt[n]    = 8'(g);
  endtask

  function automatic int addr_of(input int h, input int w, input int k);
    return (h * 8 + w) * 16 + k;
  endfunction

  // Reference accumulate with per-step clamping; returns the number of dropped entries.
  function automatic int apply_model(input int l);
    int drops = 0;
    for (int n = 0; n < l; n++) begin
      int h = int'(rf[n][0]);
      int w = int'(rf[n][1]);
      int k = int'(rf[n][2]);
      if (h < 8 && w < 8 && k < 16) begin
        longint s = longint'(model[addr_of(h, w, k)]) + longint'(int'(act) * int'(wt[n]));
        if (s > 8388607)  s = 8388607;
        if (s < -8388608) s = -8388608;
        model[addr_of(h, w, k)] = int'(s);
      end else begin
        drops++;
      end
    end
    return drops;
  endfunction

  task automatic read_addr(input int a);
    rd_if.i_rd_en   = 1'b1;
    rd_if.i_rd_addr = ADDR_W'(a);
    exp_q.push_back(model[a]);
    tick();
    rd_if.i_rd_en = 1'b0;
    check($sformatf("rd[%0d]", a), rd_if.o_rd_data, exp_q.pop_front());
  endtask

  task automatic sweep_all();
    for (int a = 0; a < DEPTH; a++) read_addr(a);
  endtask

  task automatic do_clear();
    int cyc = 0;
    bit fin = 0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    while (!fin && cyc < DEPTH + 20) begin
      tick();
      cyc++;
      if (o_finish) fin = 1;
    end
    check("clear_finish_cyc", cyc, DEPTH + 1);
    for (int a = 0; a < DEPTH; a++) model[a] = 0;
  endtask

  task automatic run(input int l, input bit poke);
    int cyc = 0;
    bit fin = 0;
    int drops;
    psum_t pre_rd;
    pre_rd  = rd_if.o_rd_data;
    len     = 11'(l);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (!fin && cyc < 2000) begin
      tick();
      cyc++;
      if (o_finish) begin
        fin = 1;
      end else if (poke && cyc == 2) begin
        check("busy_in_run", o_busy, 1);
        i_start = 1'b1;
        i_clear = 1'b1;
        rd_if.i_rd_en   = 1'b1;
        rd_if.i_rd_addr = '0;
      end else if (poke && cyc == 3) begin
        i_start = 1'b0;
        i_clear = 1'b0;
        rd_if.i_rd_en = 1'b0;
        check("rd_hold_in_run", rd_if.o_rd_data, pre_rd);
      end
    end
    check($sformatf("finish_cyc_L%0d", l), cyc, (l == 0) ? 1 : l + 3);
    drops = apply_model(l);
    check("drop_cnt", o_drop_cnt, drops);
    tick();
    check("busy_after", o_busy, 0);
    check("finish_pulse", o_finish, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_clear = 1'b0;
    i_start = 1'b0;
    len = '0;
    act = '0;
    rd_if.i_rd_en = 1'b0;
    rd_if.i_rd_addr = '0;
    for (int n = 0; n < LEN; n++) set_entry(n, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_finish", o_finish, 0);
    check("rst_drop", o_drop_cnt, 0);
    check("rst_rd_data", rd_if.o_rd_data, 0);
    rst_n = 1'b1;
    tick();

    // Basic scatter: psum[0]=6, psum[163]=-8, psum[1023]=10, rest zero.
    do_clear();
    act = 8'sd2;
    set_entry(0, 0, 0, 0, 3);
    set_entry(1, 1, 2, 3, -4);
    set_entry(2, 7, 7, 15, 5);
    run(3, 0);
    check("model_163", model[163], -8);
    sweep_all();

    // Back-to-back same address exercises forwarding.
    do_clear();
    act = 8'sd1;
    for (int n = 0; n < 4; n++) set_entry(n, 2, 2, 2, 1);
    run(4, 0);
    read_addr(290);
    do_clear();
    set_entry(0, 2, 2, 2, 1);
    set_entry(1, 1, 1, 1, 1);
    set_entry(2, 2, 2, 2, 1);
    set_entry(3, 1, 1, 1, 1);
    run(4, 0);
    read_addr(290);
    read_addr(addr_of(1, 1, 1));

    // Out-of-range entries are dropped, aliased addresses stay untouched.
    do_clear();
    act = 8'sd3;
    set_entry(0, 0, 0, 1, 7);
    set_entry(1, 127, 0, 0, 9);
    set_entry(2, 0, 8, 0, 9);
    set_entry(3, 0, 0, 16, 9);
    set_entry(4, 3, 4, 5, -6);
    run(5, 0);
    read_addr(1);
    read_addr(addr_of(3, 4, 5));
    read_addr(896);
    read_addr(128);
    read_addr(16);

    // Saturation at both rails.
    do_clear();
    act = 8'sd127;
    for (int n = 0; n < 600; n++) set_entry(n, 3, 3, 3, 127);
    run(600, 0);
    read_addr(addr_of(3, 3, 3));
    check("sat_pos", model[addr_of(3, 3, 3)], 8388607);
    for (int n = 0; n < 600; n++) set_entry(n, 4, 4, 4, -127);
    run(600, 0);
    read_addr(addr_of(4, 4, 4));
    check("sat_neg", model[addr_of(4, 4, 4)], -8388608);

    // Zero-length run: finish at cycle 1, no writes.
    run(0, 0);
    read_addr(addr_of(3, 3, 3));
    read_addr(addr_of(4, 4, 4));

    // Reset in the middle of a 20-entry run, then clear and rerun with ignored pokes.
    act = 8'sd1;
    for (int n = 0; n < 20; n++) set_entry(n, n % 8, (n * 3) % 8, n % 16, n + 1);
    set_entry(6, 5, 7, 6, -3);
    set_entry(7, 5, 7, 6, 4);
    len = 11'd20;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (5) tick();
    check("busy_mid_run", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_finish", o_finish, 0);
    check("midrst_drop", o_drop_cnt, 0);
    check("midrst_rd", rd_if.o_rd_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_clear();
    run(20, 1);
    sweep_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
